// File: rtl/sync_manager_pkg.sv
// Shared types for the double-buffer handover controller.
// Holds the FSM state encoding and the default write stride.
package sync_manager_pkg;

  localparam int unsigned WORD_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARMED,
    ST_LOCKED
  } state_e;

endpackage

// File: rtl/sync_manager_unit.sv
// Double-buffer write address generator with snapshot handover:
// the writer streams through two halves, the reader freezes the last full one.
module sync_manager_unit
  import sync_manager_pkg::*;
#(
  parameter int unsigned MM_ADDR_WIDTH = 32,
  parameter int unsigned WORD_BYTES    = WORD_BYTES_DEFAULT
) (
  input  logic                     SYS_aclk,
  input  logic                     SYS_areset,
  input  logic                     SM_request,
  input  logic [4:0]               SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0] SM_address,
  input  logic                     WR_valid,
  output logic [MM_ADDR_WIDTH-1:0] WR_address,
  output logic [MM_ADDR_WIDTH-1:0] RD_address,
  output logic                     RD_valid
);

  typedef logic [MM_ADDR_WIDTH-1:0] addr_t;

  function automatic addr_t calc_addr(
    input addr_t      base,
    input logic       half,
    input addr_t      idx,
    input logic [4:0] len
  );
    addr_t half_bytes;
    half_bytes = addr_t'(WORD_BYTES) << len;
    return base + (half ? half_bytes : '0) + idx * addr_t'(WORD_BYTES);
  endfunction

  state_e     state_q, state_d;
  addr_t      base_q, base_d;
  logic [4:0] len_q, len_d;
  addr_t      wc_q, wc_d;
  logic       half_q, half_d;
  addr_t      rd_addr_q, rd_addr_d;
  logic       rd_valid_q, rd_valid_d;

  addr_t wc_last;
  logic  done;
  logic  cfg_change;

  assign wc_last    = (addr_t'(1) << len_q) - addr_t'(1);
  assign done       = WR_valid && (state_q != ST_INIT) && (wc_q == wc_last);
  assign cfg_change = (SM_address != base_q) || (SM_log_length != len_q);

  always_ff @(posedge SYS_aclk or posedge SYS_areset) begin
    if (SYS_areset) begin
      state_q    <= ST_INIT;
      base_q     <= '0;
      len_q      <= '0;
      wc_q       <= '0;
      half_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      wc_q       <= wc_d;
      half_q     <= half_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    wc_d       = wc_q;
    half_d     = half_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;

    if (WR_valid && state_q != ST_INIT) begin
      wc_d = done ? '0 : wc_q + addr_t'(1);
    end

    unique case (state_q)
      ST_INIT: begin
        base_d  = SM_address;
        len_d   = SM_log_length;
        wc_d    = '0;
        half_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (done) half_d = ~half_q;
        if (cfg_change) begin
          state_d = ST_INIT;
        end else if (SM_request) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A release racing a completion wins: no handover.
        if (!SM_request) begin
          if (done) half_d = ~half_q;
          state_d = ST_IDLE;
        end else if (done) begin
          rd_addr_d  = calc_addr(base_q, half_q, '0, len_q);
          half_d     = ~half_q;
          rd_valid_d = 1'b1;
          state_d    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!SM_request) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign WR_address = calc_addr(base_q, half_q, wc_q, len_q);
  assign RD_address = rd_addr_q;
  assign RD_valid   = rd_valid_q;

endmodule

// File: tb/tb_sync_manager_unit.sv
// Scenario bench for sync_manager_unit: expected addresses are queued
// as writes are driven and checked on the following falling edge.
module tb_sync_manager_unit;

  logic        clk = 1'b0;
  logic        SYS_areset;
  logic        SM_request;
  logic [4:0]  SM_log_length;
  logic [31:0] SM_address;
  logic        WR_valid;
  logic [31:0] WR_address;
  logic [31:0] RD_address;
  logic        RD_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  sync_manager_unit dut (
    .SYS_aclk      (clk),
    .SYS_areset    (SYS_areset),
    .SM_request    (SM_request),
    .SM_log_length (SM_log_length),
    .SM_address    (SM_address),
    .WR_valid      (WR_valid),
    .WR_address    (WR_address),
    .RD_address    (RD_address),
    .RD_valid      (RD_valid)
  );

  task automatic test_reset();
    SYS_areset    = 1'b1;
    SM_request    = 1'b0;
    SM_log_length = 5'd3;
    SM_address    = 32'd10;
    WR_valid      = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (WR_address !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_wr: got %0d want 0", WR_address);
    end
    n_cmp++;
    if (RD_valid !== 1'b0 || RD_address !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_rd: got v=%b a=%0d want v=0 a=0",
               RD_valid, RD_address);
    end
    SYS_areset = 1'b0;
    exp_q.push_back(32'd10);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (WR_address !== e) begin
      n_bad++;
      $display("FAIL init_wr: got %0d want %0d", WR_address, e);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 3; k++) begin
      WR_valid = 1'b1;
      exp_q.push_back(32'd10 + 32'(4 * k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fill[%0d]: got wr=%0d v=%b want wr=%0d v=0",
                 k, WR_address, RD_valid, e);
      end
    end
    WR_valid = 1'b0;
  endtask

  task automatic test_freerun();
    for (int k = 1; k <= 13; k++) begin
      WR_valid = 1'b1;
      exp_q.push_back(32'd10 + 32'(4 * ((3 + k) % 16)));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL freerun[%0d]: got wr=%0d v=%b want wr=%0d v=0",
                 k, WR_address, RD_valid, e);
      end
    end
    WR_valid = 1'b0;
  endtask

  task automatic test_handover();
    logic ev;
    SM_request = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      WR_valid = 1'b1;
      exp_q.push_back(32'd10 + 32'(4 * (k % 8)) + (k == 8 ? 32'd32 : 32'd0));
      ev = (k == 8);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== ev) begin
        n_bad++;
        $display("FAIL handover[%0d]: got wr=%0d v=%b want wr=%0d v=%b",
                 k, WR_address, RD_valid, e, ev);
      end
    end
    n_cmp++;
    if (RD_address !== 32'd10) begin
      n_bad++;
      $display("FAIL handover_rd: got %0d want 10", RD_address);
    end
  endtask

  task automatic test_locked();
    for (int k = 1; k <= 16; k++) begin
      WR_valid = 1'b1;
      exp_q.push_back(32'd42 + 32'(4 * (k % 8)));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL locked[%0d]: got wr=%0d v=%b want wr=%0d v=1",
                 k, WR_address, RD_valid, e);
      end
    end
    WR_valid   = 1'b0;
    SM_request = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (RD_valid !== 1'b0 || RD_address !== 32'd10 || WR_address !== 32'd42) begin
      n_bad++;
      $display("FAIL release: got v=%b rd=%0d wr=%0d want v=0 rd=10 wr=42",
               RD_valid, RD_address, WR_address);
    end
    for (int k = 1; k <= 8; k++) begin
      WR_valid = 1'b1;
      exp_q.push_back(k == 8 ? 32'd10 : 32'd42 + 32'(4 * k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL post_release[%0d]: got wr=%0d v=%b want wr=%0d v=0",
                 k, WR_address, RD_valid, e);
      end
    end
    WR_valid = 1'b0;
  endtask

  task automatic test_pulse();
    SM_request = 1'b1;
    @(negedge clk);
    SM_request = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (RD_valid !== 1'b0 || WR_address !== 32'd10) begin
      n_bad++;
      $display("FAIL pulse: got v=%b wr=%0d want v=0 wr=10",
               RD_valid, WR_address);
    end
    for (int k = 1; k <= 16; k++) begin
      WR_valid = 1'b1;
      exp_q.push_back(32'd10 + 32'(4 * (k % 16)));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL pulse_run[%0d]: got wr=%0d v=%b want wr=%0d v=0",
                 k, WR_address, RD_valid, e);
      end
    end
    WR_valid = 1'b0;
  endtask

  task automatic test_boundary();
    for (int k = 1; k <= 16; k++) begin
      WR_valid   = 1'b1;
      SM_request = (k >= 8 && k <= 15);
      exp_q.push_back(k == 16 ? 32'd10 : 32'd10 + 32'(4 * k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e || RD_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL boundary[%0d]: got wr=%0d v=%b want wr=%0d v=0",
                 k, WR_address, RD_valid, e);
      end
    end
    WR_valid   = 1'b0;
    SM_request = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (RD_valid !== 1'b0 || WR_address !== 32'd10) begin
      n_bad++;
      $display("FAIL boundary_end: got v=%b wr=%0d want v=0 wr=10",
               RD_valid, WR_address);
    end
  endtask

  task automatic test_async_reset();
    SM_request = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      WR_valid = 1'b1;
      @(negedge clk);
    end
    WR_valid = 1'b0;
    n_cmp++;
    if (RD_valid !== 1'b1 || WR_address !== 32'd42 || RD_address !== 32'd10) begin
      n_bad++;
      $display("FAIL relock: got v=%b wr=%0d rd=%0d want v=1 wr=42 rd=10",
               RD_valid, WR_address, RD_address);
    end
    #2 SYS_areset = 1'b1;
    #1;
    n_cmp++;
    if (RD_valid !== 1'b0 || WR_address !== 32'd0 || RD_address !== 32'd0) begin
      n_bad++;
      $display("FAIL async_rst: got v=%b wr=%0d rd=%0d want 0 0 0",
               RD_valid, WR_address, RD_address);
    end
    @(negedge clk);
    SYS_areset = 1'b0;
    SM_request = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (RD_valid !== 1'b0 || WR_address !== 32'd10) begin
      n_bad++;
      $display("FAIL after_rst: got v=%b wr=%0d want v=0 wr=10",
               RD_valid, WR_address);
    end
  endtask

  task automatic test_cfg_change();
    SM_log_length = 5'd2;
    @(negedge clk);
    WR_valid = 1'b1;
    exp_q.push_back(32'd10);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (WR_address !== e) begin
      n_bad++;
      $display("FAIL init_ignore: got %0d want %0d", WR_address, e);
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(32'd10 + 32'(4 * k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (WR_address !== e) begin
        n_bad++;
        $display("FAIL cfg_len2[%0d]: got %0d want %0d", k, WR_address, e);
      end
    end
    WR_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_freerun();
    test_handover();
    test_locked();
    test_pulse();
    test_boundary();
    test_async_reset();
    test_cfg_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
